// File: rtl/lms_adapt_ctrl_if.sv
// Sample-pair handshake plus filter-step bus between the LMS adaptation
// controller (slave view) and its sample source / filter datapath (master view).
interface lms_adapt_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_x;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] f_x;
    logic [WIDTH-1:0] f_d;
    logic             f_en;
    logic             f_adapt;
    logic             f_clr;
    logic [7:0]       f_mu;
    logic [WIDTH-1:0] f_e;

    modport slave (
        input  s_valid, s_x, s_d, f_e,
        output s_ready, f_x, f_d, f_en, f_adapt, f_clr, f_mu
    );

    modport master (
        output s_valid, s_x, s_d, f_e,
        input  s_ready, f_x, f_d, f_en, f_adapt, f_clr, f_mu
    );
endinterface

// File: rtl/lms_adapt_ctrl.sv
// LMS adaptation controller: clear -> train -> track sequencing with windowed
// |e| accounting for convergence, divergence and training timeout.
module lms_adapt_ctrl #(
    parameter int          WIDTH    = 8,
    parameter int          WIN_LOG2 = 4,
    parameter logic [7:0]  MU_TRAIN = 8'd26,
    parameter logic [7:0]  MU_TRACK = 8'd6,
    parameter logic [15:0] CONV_TH  = 16'd64,
    parameter logic [15:0] DIV_TH   = 16'd512,
    parameter logic [7:0]  MAX_WIN  = 8'd32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      freeze,
    lms_adapt_ctrl_if.slave           bus,
    output logic [1:0]                state,
    output logic                      converged,
    output logic                      timeout,
    output logic [WIDTH+WIN_LOG2-1:0] win_sum
);
    localparam int AW = WIDTH + WIN_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        TRAIN = 2'd2,
        TRACK = 2'd3
    } state_t;

    state_t              st;
    state_t              nxt;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       sum;
    logic [WIN_LOG2-1:0] cnt;
    logic [7:0]          twin;
    logic [7:0]          twin_nxt;
    logic                tout_nxt;
    logic [WIDTH-1:0]    abs_e;
    logic                active;
    logic                accept;
    logic                step_in_win;
    logic                win_done;

    assign state       = st;
    assign active      = (st == TRAIN) || (st == TRACK);
    assign accept      = bus.s_valid && bus.s_ready;
    // A step issued after a stop lands in IDLE and is kept out of the window.
    assign step_in_win = bus.f_en && active;
    assign win_done    = step_in_win && (cnt == {WIN_LOG2{1'b1}});
    assign sum         = acc + AW'(abs_e);

    always_comb begin
        abs_e = bus.f_e;
        if (bus.f_e[WIDTH-1]) begin
            if (bus.f_e[WIDTH-2:0] == '0)
                abs_e = {1'b0, {(WIDTH-1){1'b1}}};
            else
                abs_e = -bus.f_e;
        end
    end

    always_comb begin
        nxt      = st;
        twin_nxt = twin;
        tout_nxt = timeout;
        case (st)
            IDLE: begin
                if (start)
                    nxt = CLEAR;
            end
            CLEAR: begin
                nxt      = TRAIN;
                twin_nxt = '0;
                tout_nxt = 1'b0;
            end
            TRAIN: begin
                if (win_done) begin
                    if (32'(sum) < 32'(CONV_TH)) begin
                        nxt = TRACK;
                    end else begin
                        if (twin != MAX_WIN)
                            twin_nxt = twin + 8'd1;
                        if (twin_nxt == MAX_WIN)
                            tout_nxt = 1'b1;
                    end
                end
            end
            TRACK: begin
                if (win_done && (32'(sum) > 32'(DIV_TH))) begin
                    nxt      = TRAIN;
                    twin_nxt = '0;
                end
            end
            default: nxt = IDLE;
        endcase
        if (stop)
            nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            bus.s_ready <= 1'b0;
            bus.f_x     <= '0;
            bus.f_d     <= '0;
            bus.f_en    <= 1'b0;
            bus.f_adapt <= 1'b0;
            bus.f_clr   <= 1'b0;
            bus.f_mu    <= MU_TRAIN;
            converged   <= 1'b0;
            timeout     <= 1'b0;
            win_sum     <= '0;
            acc         <= '0;
            cnt         <= '0;
            twin        <= '0;
        end else begin
            st          <= nxt;
            bus.s_ready <= (nxt == TRAIN) || (nxt == TRACK);
            bus.f_clr   <= (nxt == CLEAR);
            converged   <= (nxt == TRACK);
            twin        <= twin_nxt;
            timeout     <= tout_nxt;
            bus.f_en    <= accept;
            bus.f_adapt <= accept && !freeze;
            if (accept) begin
                bus.f_x  <= bus.s_x;
                bus.f_d  <= bus.s_d;
                bus.f_mu <= (st == TRACK) ? MU_TRACK : MU_TRAIN;
            end
            if (st == CLEAR) begin
                acc <= '0;
                cnt <= '0;
            end else if (step_in_win) begin
                cnt <= cnt + WIN_LOG2'(1);
                if (win_done) begin
                    win_sum <= sum;
                    acc     <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end
endmodule
